// File: rtl/pipelined_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: ALU mode encoding,
// default geometry and the stage-0 carry-in selection.
package pipelined_addsub_pkg;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_mode_e;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

    // SUB forms a + ~b + 1, so the external carry-in is only honoured in ADD mode.
    function automatic logic carry_in0(input alu_mode_e mode, input logic cin);
        return (mode == ALU_SUB) ? 1'b1 : cin;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One CHUNK-wide slice of the ripple: combinational a + b + cin, plus the carry
// into the slice MSB so the final slice can derive signed overflow.
module addsub_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         msb_cin
);

    logic [W:0] total;

    assign total   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign s       = total[W-1:0];
    assign cout    = total[W];
    assign msb_cin = a[W-1] ^ b[W-1] ^ s[W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice per stage, carry and
// partial sum carried stage to stage, with a whole-pipe valid/ready stall.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_geometry
        $error("pipelined_addsub: WIDTH must be a non-zero multiple of STAGES");
    end

    alu_mode_e        mode;
    logic [WIDTH-1:0] b_in;
    logic             advance;

    // Per-stage inputs (from the ports or the previous stage) and next-state values.
    logic             v_in    [STAGES];
    logic [WIDTH-1:0] op_a    [STAGES];
    logic [WIDTH-1:0] op_b    [STAGES];
    logic             op_c    [STAGES];
    logic [WIDTH-1:0] sum_in  [STAGES];
    logic [CHUNK-1:0] s_w     [STAGES];
    logic             c_w     [STAGES];
    logic             m_w     [STAGES];

    logic             valid_d [STAGES];
    logic             carry_d [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic [WIDTH-1:0] a_sk_d  [STAGES];
    logic [WIDTH-1:0] b_sk_d  [STAGES];

    logic             valid_q [STAGES];
    logic             carry_q [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] a_sk_q  [STAGES];
    logic [WIDTH-1:0] b_sk_q  [STAGES];
    logic             msb_cin_q;
    logic             msb_cin_d;

    assign mode     = alu_mode_e'(sub);
    assign b_in     = (mode == ALU_SUB) ? ~b : b;
    assign advance  = !valid_q[STAGES-1] || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign v_in[k]   = in_valid;
            assign op_a[k]   = a;
            assign op_b[k]   = b_in;
            assign op_c[k]   = carry_in0(mode, cin);
            assign sum_in[k] = '0;
        end else begin : g_next
            assign v_in[k]   = valid_q[k-1];
            assign op_a[k]   = a_sk_q[k-1];
            assign op_b[k]   = b_sk_q[k-1];
            assign op_c[k]   = carry_q[k-1];
            assign sum_in[k] = sum_q[k-1];
        end

        addsub_chunk #(.W(CHUNK)) u_chunk (
            .a       (op_a[k][CHUNK-1:0]),
            .b       (op_b[k][CHUNK-1:0]),
            .cin     (op_c[k]),
            .s       (s_w[k]),
            .cout    (c_w[k]),
            .msb_cin (m_w[k])
        );

        // Operand skew is kept right-aligned so every stage consumes the low chunk;
        // the vacated upper bits are constant zero and fall away in synthesis.
        assign valid_d[k] = v_in[k];
        assign carry_d[k] = c_w[k];
        assign sum_d[k]   = sum_in[k] | (WIDTH'(s_w[k]) << (k * CHUNK));
        assign a_sk_d[k]  = op_a[k] >> CHUNK;
        assign b_sk_d[k]  = op_b[k] >> CHUNK;
    end

    assign msb_cin_d = m_w[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                sum_q[k]   <= '0;
                a_sk_q[k]  <= '0;
                b_sk_q[k]  <= '0;
            end
            msb_cin_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                carry_q[k] <= carry_d[k];
                sum_q[k]   <= sum_d[k];
                a_sk_q[k]  <= a_sk_d[k];
                b_sk_q[k]  <= b_sk_d[k];
            end
            msb_cin_q <= msb_cin_d;
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign overflow  = msb_cin_q ^ carry_q[STAGES-1];
    // Qualified by valid so the flag reads 0 out of reset rather than reporting the cleared sum.
    assign zero      = valid_q[STAGES-1] && (sum_q[STAGES-1] == '0);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: directed ADD/SUB/wrap vectors,
// back-pressure, mid-stream reset and a randomized stream against a reference model.
module tb_pipelined_addsub;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         zero;

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
    } op_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    typedef struct {
        logic         ir;
        logic         ov;
        logic [W-1:0] s;
        int           nres;
    } snap_t;

    op_t   op_q[$];
    res_t  res_q[$];
    int    acc_q[$];
    int    out_q[$];
    snap_t snap_q[$];
    bit    rp_q[$];

    // Reference: plain wide arithmetic for sum/carry, signed integer range for overflow.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        res_t   r;
        logic [W:0] full;
        longint sx, sy, v, maxv, minv;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        maxv = (longint'(1) << (W - 1)) - 1;
        minv = -(longint'(1) << (W - 1));
        if (s) begin
            full = {1'b0, x} + ({1'b0, ~y} + 1);
            v    = sx - sy;
        end else begin
            full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
            v    = sx + sy + longint'(c);
        end
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (v > maxv) || (v < minv);
        r.zero = (full[W-1:0] == '0);
        return r;
    endfunction

    // Drives op_q, collects n_out results; rp_q (if set) overrides out_ready per cycle.
    task automatic stream(input int n_out, input int gap_pct, input int stall_pct);
        int idx = 0;
        int budget = 20000;
        res_q.delete(); acc_q.delete(); out_q.delete(); snap_q.delete();
        while ((idx < op_q.size() || res_q.size() < n_out) && budget > 0) begin
            @(negedge clk);
            if (snap_q.size() < rp_q.size()) out_ready = rp_q[snap_q.size()];
            else out_ready = ($urandom_range(99) >= stall_pct);
            if (idx < op_q.size() && $urandom_range(99) >= gap_pct) begin
                in_valid = 1'b1;
                a = op_q[idx].a; b = op_q[idx].b; cin = op_q[idx].cin; sub = op_q[idx].sub;
            end else begin
                in_valid = 1'b0;
                a = W'($urandom); b = W'($urandom);
                cin = 1'($urandom_range(1)); sub = 1'($urandom_range(1));
            end
            #1;
            snap_q.push_back('{in_ready, out_valid, sum, res_q.size()});
            if (out_valid && out_ready) begin
                res_q.push_back('{sum, cout, overflow, zero});
                out_q.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                acc_q.push_back(cyc);
                idx++;
            end
            budget--;
        end
        if (budget == 0) begin
            tests++; fails++;
            $display("FAIL stream_timeout: got %0d results, required %0d", res_q.size(), n_out);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        tests++; if (sum !== '0) begin fails++; $display("FAIL reset_sum: got %h, required 0", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL reset_cout: got %b, required 0", cout); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
        tests++; if (zero !== 1'b0) begin fails++; $display("FAIL reset_zero: got %b, required 0", zero); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_add();
        logic [W-1:0] exp_sum[3] = '{32'd14, 32'd48, 32'd192};
        res_t m;
        op_q = '{'{32'd5, 32'd9, 1'b0, 1'b0}, '{32'h10, 32'h20, 1'b0, 1'b0}, '{32'd128, 32'd64, 1'b0, 1'b0}};
        rp_q.delete();
        stream(3, 0, 0);
        tests++; if (res_q.size() != 3) begin fails++; $display("FAIL add_count: got %0d, required 3", res_q.size()); end
        for (int i = 0; i < res_q.size() && i < 3; i++) begin
            m = model(op_q[i].a, op_q[i].b, op_q[i].cin, op_q[i].sub);
            tests++; if (res_q[i].sum !== exp_sum[i]) begin fails++; $display("FAIL add_sum[%0d]: got %0d, required %0d", i, res_q[i].sum, exp_sum[i]); end
            tests++; if ({res_q[i].cout, res_q[i].ovf, res_q[i].zero} !== {m.cout, m.ovf, m.zero}) begin
                fails++; $display("FAIL add_flags[%0d]: got %b%b%b, required %b%b%b", i, res_q[i].cout, res_q[i].ovf, res_q[i].zero, m.cout, m.ovf, m.zero);
            end
            tests++; if (out_q[i] - acc_q[i] != S) begin fails++; $display("FAIL add_latency[%0d]: got %0d, required %0d", i, out_q[i] - acc_q[i], S); end
            tests++; if (acc_q[i] != acc_q[0] + i) begin fails++; $display("FAIL add_back_to_back[%0d]: accept gap %0d, required %0d", i, acc_q[i] - acc_q[0], i); end
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] es[2] = '{32'h0, 32'h8000_0000};
        logic         ec[2] = '{1'b1, 1'b0};
        logic         eo[2] = '{1'b0, 1'b1};
        logic         ez[2] = '{1'b1, 1'b0};
        op_q = '{'{32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0}, '{32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0}};
        rp_q.delete();
        stream(2, 0, 0);
        tests++; if (res_q.size() != 2) begin fails++; $display("FAIL wrap_count: got %0d, required 2", res_q.size()); end
        for (int i = 0; i < res_q.size() && i < 2; i++) begin
            tests++; if (res_q[i].sum !== es[i]) begin fails++; $display("FAIL wrap_sum[%0d]: got %h, required %h", i, res_q[i].sum, es[i]); end
            tests++; if ({res_q[i].cout, res_q[i].ovf, res_q[i].zero} !== {ec[i], eo[i], ez[i]}) begin
                fails++; $display("FAIL wrap_flags[%0d]: got c%b o%b z%b, required c%b o%b z%b", i, res_q[i].cout, res_q[i].ovf, res_q[i].zero, ec[i], eo[i], ez[i]);
            end
        end
    endtask

    task automatic test_sub();
        logic [W-1:0] es[4] = '{32'hFFFF_FFFC, 32'd4, 32'h7FFF_FFFF, 32'd4};
        logic         ec[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic         eo[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        op_q = '{'{32'd5, 32'd9, 1'b0, 1'b1}, '{32'd9, 32'd5, 1'b0, 1'b1},
                 '{32'h8000_0000, 32'd1, 1'b0, 1'b1}, '{32'd9, 32'd5, 1'b1, 1'b1}};
        rp_q.delete();
        stream(4, 0, 0);
        tests++; if (res_q.size() != 4) begin fails++; $display("FAIL sub_count: got %0d, required 4", res_q.size()); end
        for (int i = 0; i < res_q.size() && i < 4; i++) begin
            tests++; if (res_q[i].sum !== es[i]) begin fails++; $display("FAIL sub_sum[%0d]: got %h, required %h", i, res_q[i].sum, es[i]); end
            tests++; if ({res_q[i].cout, res_q[i].ovf} !== {ec[i], eo[i]}) begin
                fails++; $display("FAIL sub_flags[%0d]: got c%b o%b, required c%b o%b", i, res_q[i].cout, res_q[i].ovf, ec[i], eo[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        res_t m;
        op_q.delete();
        for (int i = 0; i < 6; i++) op_q.push_back('{W'($urandom), W'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1))});
        rp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        stream(6, 0, 0);
        rp_q.delete();
        for (int i = 5; i < 8 && i < snap_q.size(); i++) begin
            tests++; if (snap_q[i].ir !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %b, required 0", i, snap_q[i].ir); end
            tests++; if (snap_q[i].ov !== 1'b1) begin fails++; $display("FAIL bp_out_valid[%0d]: got %b, required 1", i, snap_q[i].ov); end
            m = model(op_q[snap_q[i].nres].a, op_q[snap_q[i].nres].b, op_q[snap_q[i].nres].cin, op_q[snap_q[i].nres].sub);
            tests++; if (snap_q[i].s !== m.sum) begin fails++; $display("FAIL bp_hold_sum[%0d]: got %h, required %h", i, snap_q[i].s, m.sum); end
        end
        tests++; if (res_q.size() != 6) begin fails++; $display("FAIL bp_count: got %0d, required 6", res_q.size()); end
        for (int i = 0; i < res_q.size() && i < 6; i++) begin
            m = model(op_q[i].a, op_q[i].b, op_q[i].cin, op_q[i].sub);
            tests++; if (res_q[i] !== m) begin
                fails++; $display("FAIL bp_order[%0d]: got %h/%b%b%b, required %h/%b%b%b", i, res_q[i].sum, res_q[i].cout, res_q[i].ovf, res_q[i].zero, m.sum, m.cout, m.ovf, m.zero);
            end
        end
        @(negedge clk); #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_no_duplicate: out_valid %b, required 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        res_t m;
        op_q.delete();
        for (int i = 0; i < S; i++) op_q.push_back('{W'($urandom), W'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1))});
        rp_q.delete();
        stream(0, 0, 0);
        @(negedge clk); #1;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_full: out_valid %b, required 1", out_valid); end
        #1 rst = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid: got %b, required 0", out_valid); end
        tests++; if ({sum, cout, overflow, zero} !== '0) begin
            fails++; $display("FAIL rstmid_outputs: got %h c%b o%b z%b, required all 0", sum, cout, overflow, zero);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        op_q = '{'{32'd100, 32'd23, 1'b1, 1'b0}};
        stream(1, 0, 0);
        m = model(32'd100, 32'd23, 1'b1, 1'b0);
        tests++; if (res_q.size() != 1) begin fails++; $display("FAIL rstmid_count: got %0d, required 1", res_q.size()); end
        if (res_q.size() >= 1) begin
            tests++; if (res_q[0].sum !== 32'd124) begin fails++; $display("FAIL rstmid_sum: got %0d, required 124", res_q[0].sum); end
            tests++; if (res_q[0] !== m) begin fails++; $display("FAIL rstmid_flags: got c%b o%b z%b", res_q[0].cout, res_q[0].ovf, res_q[0].zero); end
            tests++; if (out_q[0] - acc_q[0] != S) begin fails++; $display("FAIL rstmid_latency: got %0d, required %0d", out_q[0] - acc_q[0], S); end
        end
        @(negedge clk); #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_no_stale: out_valid %b, required 0", out_valid); end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(7))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    task automatic test_random();
        res_t m;
        int   bad = 0;
        op_q.delete();
        for (int i = 0; i < 1000; i++) op_q.push_back('{pick_operand(), pick_operand(), 1'($urandom_range(1)), 1'($urandom_range(1))});
        rp_q.delete();
        stream(1000, 20, 30);
        tests++; if (res_q.size() != 1000) begin fails++; $display("FAIL rand_count: got %0d, required 1000", res_q.size()); end
        for (int i = 0; i < res_q.size() && i < 1000; i++) begin
            m = model(op_q[i].a, op_q[i].b, op_q[i].cin, op_q[i].sub);
            tests++;
            if (res_q[i] !== m) begin
                fails++;
                if (bad < 10) $display("FAIL rand_op[%0d]: a=%h b=%h cin=%b sub=%b got %h/%b%b%b, required %h/%b%b%b", i, op_q[i].a, op_q[i].b, op_q[i].cin, op_q[i].sub,
                                       res_q[i].sum, res_q[i].cout, res_q[i].ovf, res_q[i].zero, m.sum, m.cout, m.ovf, m.zero);
                bad++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_wrap();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
